pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Program-counter and next-PC stage for the single-cycle MIPS32 core. Drives the
//   word address into the instruction ROM and selects the next PC:
//   sequential, branch, jump, jr, interrupt or illegal-op vector.
//   PC[31] is the kernel/supervisor bit. Also captures the exception return
//   address and counts fetched instructions.
// PARAMETERS
//   RESET_PC   32'h8000_0000  PC loaded on reset (kernel mode)
//   ILLOP_PC   32'h8000_0004  vector for an illegal/unsupported opcode
//   XADR_PC    32'h8000_0008  vector for an external interrupt
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-low reset
//   stall          in   1   hold PC, EPC and counter this cycle
//   branch_taken   in   1   conditional branch resolved taken
//   branch_imm     in   16  branch offset in words, signed
//   jump           in   1   J/JAL
//   jump_target    in   26  instr_index field
//   jr             in   1   JR/JALR
//   jr_addr        in   32  rs register value
//   irq            in   1   level interrupt request
//   illop          in   1   decoder flagged an illegal opcode
//   pc             out  32  current PC, feeds ROM addr
//   pc_plus4       out  32  {pc[31], pc[30:0]+4}, used for link and EPC
//   epc            out  32  exception return address
//   exc_taken      out  1   registered pulse: a vector was taken on the previous edge
//   fetch_count    out  32  instructions fetched since reset
// BEHAVIOUR
//   Reset (async, reset==0):
//   - pc=RESET_PC; epc=0; exc_taken=0; fetch_count=0.
//   - Reset mid-operation discards any pending selection immediately.
//   Update rule:
//   - On each rising edge with stall==0, pc<=next_pc.
//   - On that same edge fetch_count increments; it wraps at 2^32.
//   - With stall==1, pc, epc and fetch_count hold and exc_taken<=0.
//   - A held irq is taken on the first unstalled edge.
//   next_pc priority, highest first:
//   1 illop: next_pc=ILLOP_PC; epc<=pc_plus4. Taken in both user and kernel mode.
//   2 irq and pc[31]==0: next_pc=XADR_PC; epc<=pc. The current instruction is
//     discarded and re-executed on return. irq is ignored while pc[31]==1.
//   3 jr: in kernel mode next_pc=jr_addr. In user mode next_pc={1'b0,jr_addr[30:0]},
//     so user code can never enter kernel mode.
//   4 jump: next_pc={pc[31:28], jump_target, 2'b00}.
//   5 branch_taken: next_pc = pc_plus4 + (sext(branch_imm)<<2), computed on 32 bits.
//     Bit 31 is then forced to pc[31].
//   6 default: next_pc=pc_plus4.
//   Arithmetic and alignment:
//   - pc_plus4 wraps within bits [30:0]; bit 31 is preserved.
//   - next_pc[1:0] is forced to 2'b00 in all cases, so the ROM always sees word-aligned addresses.
//   Outputs:
//   - exc_taken<=1 on an unstalled edge where rule 1 or 2 fired, otherwise 0.
//   - epc changes only on those edges.
//   - Simultaneous controls resolve strictly by the priority above; lower requests are dropped.
//   - Latency: the ROM sees the new pc one edge after the controls are presented.
//     The combinational outputs pc and pc_plus4 settle within the same cycle.
// TESTING
//   T1 reset low mid-run -> pc=8000_0000, epc=0, fetch_count=0 asynchronously.
//      Release -> pc steps 8000_0004, 8000_0008, and so on.
//   T2 pc=0000_0028, branch_taken=1, branch_imm=16'hFFF8 -> pc=0000_000C next edge.
//   T3 pc=0000_0008, jump=1, jump_target=26'h010000A -> pc=0040_0028.
//   T4 irq=1 with pc=0000_0010 -> pc=8000_0008, epc=0000_0010, exc_taken=1 one cycle.
//      irq=1 with pc=8000_0010 -> pc=8000_0014, no exception.
//   T5 illop=1, irq=1 and jr=1 in the same cycle with pc=0000_0020 ->
//      pc=8000_0004, epc=0000_0024.
//      Separately, user-mode jr to 8000_1000 -> pc=0000_1000.
//   T6 stall=1 for 3 cycles with irq=1 -> pc, epc and fetch_count frozen, exc_taken=0.
//      First unstalled edge -> vector taken. Also check pc=7FFF_FFFC +4 -> pc=0000_0000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and next-PC selection for the MIPS32 core,
//               with exception return address and fetch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
   parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   input  logic        irq,
   input  logic        illop,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] epc,
   output logic        exc_taken,
   output logic [31:0] fetch_count
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic        exc_q, exc_d;
   logic [31:0] cnt_q, cnt_d;

   logic        kernel;
   logic [31:0] seq_pc;
   logic [31:0] br_off;
   logic [31:0] br_sum;
   logic [31:0] sel_pc;
   logic        take_exc;
   logic [31:0] exc_epc;

   assign kernel = pc_q[31];

   // The supervisor bit never changes through sequential flow or branches.
   assign seq_pc = {pc_q[31], pc_q[30:0] + 31'd4};
   assign br_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};
   assign br_sum = seq_pc + br_off;

   always_comb begin
      sel_pc   = seq_pc;
      take_exc = 1'b0;
      exc_epc  = epc_q;
      if (illop) begin
         sel_pc   = ILLOP_PC;
         take_exc = 1'b1;
         exc_epc  = seq_pc;
      end else if (irq && !kernel) begin
         // Interrupted instruction is replayed on return, so save pc itself.
         sel_pc   = XADR_PC;
         take_exc = 1'b1;
         exc_epc  = pc_q;
      end else if (jr) begin
         sel_pc = kernel ? jr_addr : {1'b0, jr_addr[30:0]};
      end else if (jump) begin
         sel_pc = {pc_q[31:28], jump_target, 2'b00};
      end else if (branch_taken) begin
         sel_pc = {pc_q[31], br_sum[30:0]};
      end
   end

   always_comb begin
      pc_d  = pc_q;
      epc_d = epc_q;
      exc_d = 1'b0;
      cnt_d = cnt_q;
      if (!stall) begin
         pc_d  = {sel_pc[31:2], 2'b00};
         epc_d = exc_epc;
         exc_d = take_exc;
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_PC;
         epc_q <= 32'h0;
         exc_q <= 1'b0;
         cnt_q <= 32'h0;
      end else begin
         pc_q  <= pc_d;
         epc_q <= epc_d;
         exc_q <= exc_d;
         cnt_q <= cnt_d;
      end
   end

   assign pc          = pc_q;
   assign pc_plus4    = seq_pc;
   assign epc         = epc_q;
   assign exc_taken   = exc_q;
   assign fetch_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed-vector bench with a queue scoreboard for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, branch_taken, jump, jr, irq, illop;
   logic [15:0] branch_imm;
   logic [25:0] jump_target;
   logic [31:0] jr_addr;
   logic [31:0] pc, pc_plus4, epc, fetch_count;
   logic        exc_taken;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pp4;
      logic [31:0] epc;
      logic        exc;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sbq[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] e_cnt  = 32'h0;

   pc_fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_taken(branch_taken), .branch_imm(branch_imm),
      .jump(jump), .jump_target(jump_target),
      .jr(jr), .jr_addr(jr_addr),
      .irq(irq), .illop(illop),
      .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
      .exc_taken(exc_taken), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clr();
      stall = 0; branch_taken = 0; branch_imm = '0; jump = 0;
      jump_target = '0; jr = 0; jr_addr = '0; irq = 0; illop = 0;
   endtask

   // Inputs are already driven; queue the state expected after the next edge.
   task automatic go(input logic [31:0] xpc, input logic [31:0] xepc, input logic xexc);
      exp_t e;
      if (!stall) e_cnt = e_cnt + 32'd1;
      e.pc  = xpc;
      e.pp4 = {xpc[31], xpc[30:0] + 31'd4};
      e.epc = xepc;
      e.exc = xexc;
      e.cnt = e_cnt;
      sbq.push_back(e);
      @(posedge clk);
      #2;
      clr();
   endtask

   always begin
      exp_t m;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
         m = sbq.pop_front();
         chk("pc", pc, m.pc);
         chk("pc_plus4", pc_plus4, m.pp4);
         chk("epc", epc, m.epc);
         chk("exc_taken", {31'h0, exc_taken}, {31'h0, m.exc});
         chk("fetch_count", fetch_count, m.cnt);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      clr();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_pc", pc, 32'h8000_0000);
      chk("rst_epc", epc, 32'h0);
      chk("rst_cnt", fetch_count, 32'h0);
      reset = 1'b1;

      go(32'h8000_0004, 32'h0, 1'b0);
      go(32'h8000_0008, 32'h0, 1'b0);
      jr = 1; jr_addr = 32'h0000_0028;            go(32'h0000_0028, 32'h0, 1'b0);
      branch_taken = 1; branch_imm = 16'hFFF8;    go(32'h0000_000C, 32'h0, 1'b0);
      jr = 1; jr_addr = 32'h0000_0008;            go(32'h0000_0008, 32'h0, 1'b0);
      jump = 1; jump_target = 26'h010000A;        go(32'h0040_0028, 32'h0, 1'b0);
      jr = 1; jr_addr = 32'h0000_0010;            go(32'h0000_0010, 32'h0, 1'b0);
      irq = 1;                                    go(32'h8000_0008, 32'h10, 1'b1);
      go(32'h8000_000C, 32'h10, 1'b0);
      go(32'h8000_0010, 32'h10, 1'b0);
      irq = 1;                                    go(32'h8000_0014, 32'h10, 1'b0);
      jr = 1; jr_addr = 32'h0000_0020;            go(32'h0000_0020, 32'h10, 1'b0);
      illop = 1; irq = 1; jr = 1; jr_addr = 32'h1234;
      go(32'h8000_0004, 32'h24, 1'b1);
      jr = 1; jr_addr = 32'h0000_0100;            go(32'h0000_0100, 32'h24, 1'b0);
      jr = 1; jr_addr = 32'h8000_1000;            go(32'h0000_1000, 32'h24, 1'b0);
      for (int i = 0; i < 3; i++) begin
         stall = 1; irq = 1;                      go(32'h0000_1000, 32'h24, 1'b0);
      end
      irq = 1;                                    go(32'h8000_0008, 32'h1000, 1'b1);
      stall = 1;                                  go(32'h8000_0008, 32'h1000, 1'b0);
      jr = 1; jr_addr = 32'h7FFF_FFFC;            go(32'h7FFF_FFFC, 32'h1000, 1'b0);
      go(32'h0000_0000, 32'h1000, 1'b0);
      branch_taken = 1; branch_imm = 16'h8000;    go(32'h7FFE_0004, 32'h1000, 1'b0);
      jr = 1; jr_addr = 32'h0000_0013;            go(32'h0000_0010, 32'h1000, 1'b0);

      // Asynchronous reset between edges with the bus idle.
      reset = 1'b0;
      #1;
      chk("arst_pc", pc, 32'h8000_0000);
      chk("arst_epc", epc, 32'h0);
      chk("arst_cnt", fetch_count, 32'h0);
      chk("arst_exc", {31'h0, exc_taken}, 32'h0);
      e_cnt = 32'h0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      go(32'h8000_0004, 32'h0, 1'b0);
      go(32'h8000_0008, 32'h0, 1'b0);

      @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got %0d expected 0 pending", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
